// File: rtl/prim_gf_mac.sv
// Digit-serial GF(2^Width) multiplier with a GHASH-style multiply-accumulate mode.
// Define PRIM_GF_MAC_SCRUB_EN to zero the datapath registers when a result is consumed.
module prim_gf_mac #(
    parameter int              Width          = 32,
    parameter int              StagesPerCycle = Width,
    parameter logic [Width-1:0] IPoly         = 32'h0000_008D
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             mode_i,
    input  logic             clr_acc_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] prod_o,
    output logic [Width-1:0] acc_o
);

    localparam int Loops = Width / StagesPerCycle;
    localparam int CntW  = (Loops > 1) ? $clog2(Loops) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Loops - 1);

    if ((Width % StagesPerCycle) != 0 || (StagesPerCycle & (StagesPerCycle - 1)) != 0)
    begin : g_bad_cfg
        $error("prim_gf_mac: StagesPerCycle must be a power of two dividing Width");
    end

    typedef enum logic [1:0] {Idle, Busy, Done} state_e;

    state_e              state_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic                mode_reg;
    logic [CntW-1:0]     cnt_reg;
    logic [Width-1:0]    shift_reg;
    logic [Width-1:0]    b_reg;
    logic [Width-1:0]    pp_reg;
    logic [Width-1:0]    prod_reg;
    logic [Width-1:0]    acc_reg;

    logic [Width-1:0]          acc_in;
    logic [Width-1:0]          a_eff;
    logic [StagesPerCycle-1:0] b_slice;
    logic [Width-1:0]          mul_chain [StagesPerCycle+1];
    logic [Width-1:0]          pp_chain  [StagesPerCycle+1];

    // A clear issued together with a MAC request means this block starts a fresh hash.
    assign acc_in  = clr_acc_i ? '0 : acc_reg;
    assign a_eff   = mode_i ? (acc_in ^ operand_a_i) : operand_a_i;
    assign b_slice = b_reg[cnt_reg*StagesPerCycle +: StagesPerCycle];

    assign mul_chain[0] = shift_reg;
    assign pp_chain[0]  = pp_reg;

    for (genvar gi = 0; gi < StagesPerCycle; gi++) begin : g_stage
        assign pp_chain[gi+1]  = pp_chain[gi] ^ (b_slice[gi] ? mul_chain[gi] : '0);
        // Multiply by x, folding the overflowing x^Width term back in via IPoly.
        assign mul_chain[gi+1] = {mul_chain[gi][Width-2:0], 1'b0}
                               ^ (mul_chain[gi][Width-1] ? IPoly : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= Idle;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            mode_reg      <= 1'b0;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            b_reg         <= '0;
            pp_reg        <= '0;
            prod_reg      <= '0;
            acc_reg       <= '0;
        end else begin
            case (state_reg)
                Idle: begin
                    if (clr_acc_i) begin
                        acc_reg <= '0;
                    end
                    if (in_valid_i) begin
                        shift_reg    <= a_eff;
                        b_reg        <= operand_b_i;
                        mode_reg     <= mode_i;
                        pp_reg       <= '0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= Busy;
                    end
                end
                Busy: begin
                    shift_reg <= mul_chain[StagesPerCycle];
                    pp_reg    <= pp_chain[StagesPerCycle];
                    if (cnt_reg == LastCnt) begin
                        prod_reg      <= pp_chain[StagesPerCycle];
                        if (mode_reg) begin
                            acc_reg <= pp_chain[StagesPerCycle];
                        end
                        out_valid_reg <= 1'b1;
                        state_reg     <= Done;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                Done: begin
                    if (out_ready_i) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= Idle;
`ifdef PRIM_GF_MAC_SCRUB_EN
                        shift_reg <= '0;
                        b_reg     <= '0;
                        pp_reg    <= '0;
                        prod_reg  <= '0;
`endif
                    end
                end
                default: begin
                    state_reg <= Idle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_reg;
    assign out_valid_o = out_valid_reg;
    assign prod_o      = prod_reg;
    assign acc_o       = acc_reg;

endmodule

// File: tb/tb_prim_gf_mac.sv
// Directed bench for prim_gf_mac in GF(2^8) (AES polynomial): a 2-bit digit-serial
// instance and a fully parallel instance, sharing stimulus through a select.
module tb_prim_gf_mac;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       mode;
    logic       clr_acc;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       out_ready;
    int         sel;

    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0] prod_a, acc_a, prod_b, acc_b;

    logic       in_ready, out_valid;
    logic [7:0] prod, acc;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prim_gf_mac #(.Width(8), .StagesPerCycle(2), .IPoly(8'h1B)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid && sel == 0), .in_ready_o(in_ready_a),
        .mode_i(mode), .clr_acc_i(clr_acc && sel == 0),
        .operand_a_i(op_a), .operand_b_i(op_b),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready && sel == 0),
        .prod_o(prod_a), .acc_o(acc_a)
    );

    prim_gf_mac #(.Width(8), .StagesPerCycle(8), .IPoly(8'h1B)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid && sel == 1), .in_ready_o(in_ready_b),
        .mode_i(mode), .clr_acc_i(clr_acc && sel == 1),
        .operand_a_i(op_a), .operand_b_i(op_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready && sel == 1),
        .prod_o(prod_b), .acc_o(acc_b)
    );

    assign in_ready  = (sel == 0) ? in_ready_a  : in_ready_b;
    assign out_valid = (sel == 0) ? out_valid_a : out_valid_b;
    assign prod      = (sel == 0) ? prod_a      : prod_b;
    assign acc       = (sel == 0) ? acc_a       : acc_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request while Idle; returns just after the accepting edge.
    task automatic issue(input logic m, input logic c, input logic [7:0] a, input logic [7:0] b);
        mode = m; clr_acc = c; op_a = a; op_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; clr_acc = 1'b0;
    endtask

    // Counts edges after the accept until out_valid rises (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (out_valid) break;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        sel = 0; rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; clr_acc = 1'b0;
        op_a = '0; op_b = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_prod", prod, 8'h00);
        check("rst_acc", acc, 8'h00);

        // Plain multiply 0x57*0x83
        issue(1'b0, 1'b0, 8'h57, 8'h83);
        wait_done(lat);
        check("mul_latency", lat, 4);
        check("mul_prod", prod, 8'hC1);
        check("mul_acc", acc, 8'h00);
        check("done_in_ready", in_ready, 0);

        // Backpressure while a new request is already pending
        mode = 1'b0; op_a = 8'h02; op_b = 8'h80; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_prod", prod, 8'hC1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
`ifdef PRIM_GF_MAC_SCRUB_EN
        check("idle_prod_scrub", prod, 8'h00);
`else
        check("idle_prod_hold", prod, 8'hC1);
`endif
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        check("pend_latency", lat, 4);
        check("pend_prod", prod, 8'h1B);
        check("pend_acc", acc, 8'h00);
        handshake();

        // MAC chain with clear on the first block
        issue(1'b1, 1'b1, 8'h57, 8'h83);
        wait_done(lat);
        check("mac1_latency", lat, 4);
        check("mac1_prod", prod, 8'hC1);
        check("mac1_acc", acc, 8'hC1);
        handshake();
        issue(1'b1, 1'b0, 8'h96, 8'h13);
        wait_done(lat);
        check("mac2_prod", prod, 8'hFE);
        check("mac2_acc", acc, 8'hFE);
        handshake();
        check("idle_acc_kept", acc, 8'hFE);

        // Reset during Busy
        issue(1'b1, 1'b0, 8'h11, 8'h22);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_acc", acc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(1'b0, 1'b0, 8'h02, 8'h80);
        wait_done(lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_prod", prod, 8'h1B);
        handshake();

        // Standalone clear while Idle
        issue(1'b1, 1'b0, 8'h01, 8'h01);
        wait_done(lat);
        check("mac_unit_acc", acc, 8'h01);
        handshake();
        clr_acc = 1'b1;
        tick();
        clr_acc = 1'b0;
        check("clr_acc", acc, 8'h00);
        check("clr_out_valid", out_valid, 0);
        check("clr_in_ready", in_ready, 1);

        // Fully parallel instance
        sel = 1;
        issue(1'b0, 1'b0, 8'h02, 8'h87);
        wait_done(lat);
        check("par_latency", lat, 1);
        check("par_prod", prod, 8'h15);
        handshake();
        issue(1'b0, 1'b0, 8'h5A, 8'h00);
        wait_done(lat);
        check("par_b_zero", prod, 8'h00);
        handshake();
        issue(1'b0, 1'b0, 8'hA5, 8'h01);
        wait_done(lat);
        check("par_b_one", prod, 8'hA5);
        check("par_acc", acc, 8'h00);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
